// File: rtl/mealy_stim_sched_if.sv
// Config/stimulus bundle for mealy_stim_sched.
// master: pin-side controller plus the Mealy FSM output (z_in); slave: the sequencer.
interface mealy_stim_sched_if #(
   parameter int unsigned PAT_W = 16,
   parameter int unsigned LEN_W = 5,
   parameter int unsigned DIV_W = 8
);
   logic             start;
   logic             abort;
   logic [PAT_W-1:0] pat;
   logic [LEN_W-1:0] len;
   logic [DIV_W-1:0] div;
   logic             z_in;
   logic             x_out;
   logic             step;
   logic             fsm_clr;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] z_count;
   logic [PAT_W-1:0] z_cap;

   modport master (
      output start, abort, pat, len, div, z_in,
      input  x_out, step, fsm_clr, busy, done, z_count, z_cap
   );

   modport slave (
      input  start, abort, pat, len, div, z_in,
      output x_out, step, fsm_clr, busy, done, z_count, z_cap
   );
endinterface

// File: rtl/mealy_stim_sched.sv
// Serial stimulus sequencer for the single-input Mealy FSM: clears the FSM, plays a latched
// pattern LSB-first with one step strobe per bit, and counts Mealy output hits.
// Optional per-bit z history: define MEALY_SCHED_CAPTURE_EN to build the z_cap flops.
module mealy_stim_sched #(
   parameter int unsigned PAT_W = 16,
   parameter int unsigned LEN_W = 5,
   parameter int unsigned DIV_W = 8
) (
   input logic               clk,
   input logic               rst,
   mealy_stim_sched_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StClr, StSend, StDone} state_e;

   state_e           state_q, state_d;
   logic [PAT_W-1:0] shift_q, shift_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] timer_q, timer_d;
   logic [LEN_W-1:0] bits_left_q, bits_left_d;
   logic [LEN_W-1:0] z_count_q, z_count_d;

   logic             accept;
   logic             step_fire;
   logic             x_out;
   logic             fsm_clr;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] len_clamped;

   // Requests longer than the pattern register are cut to PAT_W bits.
   assign len_clamped = (bus.len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         len_q       <= '0;
         div_q       <= '0;
         timer_q     <= '0;
         bits_left_q <= '0;
         z_count_q   <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         len_q       <= len_d;
         div_q       <= div_d;
         timer_q     <= timer_d;
         bits_left_q <= bits_left_d;
         z_count_q   <= z_count_d;
      end
   end

   // Next-state and Mealy-style outputs; step is suppressed in an abort cycle.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      len_d       = len_q;
      div_d       = div_q;
      timer_d     = timer_q;
      bits_left_d = bits_left_q;
      z_count_d   = z_count_q;
      accept      = 1'b0;
      step_fire   = 1'b0;
      x_out       = 1'b0;
      fsm_clr     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         StIdle: begin
            // start wins over abort here; abort only matters once busy.
            if (bus.start) begin
               accept    = 1'b1;
               shift_d   = bus.pat;
               len_d     = len_clamped;
               div_d     = bus.div;
               z_count_d = '0;
               state_d   = StClr;
            end
         end
         StClr: begin
            busy        = 1'b1;
            fsm_clr     = 1'b1;
            timer_d     = div_q;
            bits_left_d = len_q;
            if (bus.abort) begin
               state_d = StIdle;
            end else if (len_q == '0) begin
               state_d = StDone;
            end else begin
               state_d = StSend;
            end
         end
         StSend: begin
            busy  = 1'b1;
            x_out = shift_q[0];
            if (bus.abort) begin
               state_d = StIdle;
            end else if (timer_q == '0) begin
               step_fire = 1'b1;
               if (bus.z_in) begin
                  z_count_d = z_count_q + LEN_W'(1);
               end
               // Shift and reload land on the edge closing the step cycle, so the next bit
               // is presented from the following cycle for a full div+1 window.
               shift_d     = shift_q >> 1;
               bits_left_d = bits_left_q - LEN_W'(1);
               timer_d     = div_q;
               if (bits_left_q == LEN_W'(1)) begin
                  state_d = StDone;
               end
            end else begin
               timer_d = timer_q - DIV_W'(1);
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.x_out   = x_out;
   assign bus.step    = step_fire;
   assign bus.fsm_clr = fsm_clr;
   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.z_count = z_count_q;

`ifdef MEALY_SCHED_CAPTURE_EN
   logic [PAT_W-1:0] cap_q, cap_d;
   logic [LEN_W-1:0] bit_idx;

   // Index of the bit currently on x_out.
   assign bit_idx = len_q - bits_left_q;

   // Record z_in at each step into the slot of the bit just sent.
   always_comb begin
      cap_d = cap_q;
      if (accept) begin
         cap_d = '0;
      end else if (step_fire) begin
         for (int unsigned i = 0; i < PAT_W; i++) begin
            if (LEN_W'(i) == bit_idx) begin
               cap_d[i] = bus.z_in;
            end
         end
      end
   end

   // Capture history register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q <= '0;
      end else begin
         cap_q <= cap_d;
      end
   end

   assign bus.z_cap = cap_q;
`else
   assign bus.z_cap = '0;
`endif

endmodule

// File: tb/tb_mealy_stim_sched.sv
// Directed bench for mealy_stim_sched; the FSM is replaced by z_in = x_out.
module tb_mealy_stim_sched;
   localparam int unsigned PAT_W = 16;
   localparam int unsigned LEN_W = 5;
   localparam int unsigned DIV_W = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   mealy_stim_sched_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) bus ();

   assign bus.z_in = bus.x_out;

   mealy_stim_sched #(.PAT_W(PAT_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int popcnt(input logic [15:0] v, input int n);
      int cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (v[i]) cnt++;
      end
      return cnt;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ".x_out"}, 32'(bus.x_out), 32'd0);
      check({tag, ".step"}, 32'(bus.step), 32'd0);
      check({tag, ".fsm_clr"}, 32'(bus.fsm_clr), 32'd0);
      check({tag, ".busy"}, 32'(bus.busy), 32'd0);
      check({tag, ".done"}, 32'(bus.done), 32'd0);
      check({tag, ".z_count"}, 32'(bus.z_count), 32'd0);
      check({tag, ".z_cap"}, 32'(bus.z_cap), 32'd0);
   endtask

   // One run: start at cycle 0, observe cycles 1..end+3 against the cycle formulas.
   task automatic play(input string tag, input logic [15:0] p, input logic [4:0] l,
                       input logic [7:0] d, input int abort_step, input int restart_cyc,
                       input bit abort_at_start);
      int          dv, eff_len, exp_steps, end_cyc, abort_cyc;
      int          nsteps, ndone, nclr, done_cyc, clr_cyc, bi;
      logic [15:0] exp_cap;
      dv      = int'(d);
      eff_len = (l > 5'd16) ? 16 : int'(l);
      if (abort_step >= 0) begin
         exp_steps = abort_step;
         abort_cyc = 2 + abort_step * (dv + 1) + dv;
         end_cyc   = abort_cyc;
      end else begin
         exp_steps = eff_len;
         abort_cyc = -1;
         end_cyc   = 2 + eff_len * (dv + 1);
      end
      exp_cap = '0;
      for (int i = 0; i < exp_steps; i++) exp_cap[i] = p[i];
      nsteps   = 0;
      ndone    = 0;
      nclr     = 0;
      done_cyc = -1;
      clr_cyc  = -1;

      bus.pat   = p;
      bus.len   = l;
      bus.div   = d;
      bus.start = 1'b1;
      bus.abort = abort_at_start;
      #1;
      check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);

      for (int c = 1; c <= end_cyc + 3; c++) begin
         tick();
         bus.start = (c == restart_cyc);
         bus.abort = (c == abort_cyc);
         if (c == restart_cyc) begin
            bus.pat = ~p;
            bus.len = 5'd3;
            bus.div = 8'd0;
         end
         #1;
         if (bus.fsm_clr) begin
            nclr++;
            clr_cyc = c;
         end
         if (c == 1) check({tag, ".busy_c1"}, 32'(bus.busy), 32'd1);
         if (c >= 2 && c < end_cyc) begin
            bi = (c - 2) / (dv + 1);
            check({tag, ".x_win"}, 32'(bus.x_out), 32'(p[bi]));
         end
         if (bus.step) begin
            check({tag, ".step_cyc"}, 32'(c), 32'(2 + nsteps * (dv + 1) + dv));
            nsteps++;
         end
         if (bus.done) begin
            ndone++;
            done_cyc = c;
         end
         if (c == abort_cyc) check({tag, ".abort_step"}, 32'(bus.step), 32'd0);
         if (abort_cyc >= 0 && c == abort_cyc + 1) begin
            check({tag, ".abort_busy"}, 32'(bus.busy), 32'd0);
            check({tag, ".abort_x"}, 32'(bus.x_out), 32'd0);
         end
         if (abort_cyc < 0 && c == end_cyc) begin
            check({tag, ".done_busy"}, 32'(bus.busy), 32'd0);
            check({tag, ".done_x"}, 32'(bus.x_out), 32'd0);
         end
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;

      check({tag, ".n_steps"}, 32'(nsteps), 32'(exp_steps));
      check({tag, ".n_clr"}, 32'(nclr), 32'd1);
      check({tag, ".clr_cyc"}, 32'(clr_cyc), 32'd1);
      if (abort_cyc >= 0) begin
         check({tag, ".n_done"}, 32'(ndone), 32'd0);
      end else begin
         check({tag, ".n_done"}, 32'(ndone), 32'd1);
         check({tag, ".done_cyc"}, 32'(done_cyc), 32'(end_cyc));
      end
      check({tag, ".z_count"}, 32'(bus.z_count), 32'(popcnt(p, exp_steps)));
`ifdef MEALY_SCHED_CAPTURE_EN
      check({tag, ".z_cap"}, 32'(bus.z_cap), 32'(exp_cap));
`else
      check({tag, ".z_cap"}, 32'(bus.z_cap), 32'd0);
`endif
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.pat   = '0;
      bus.len   = '0;
      bus.div   = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_all_zero("reset");

      play("div0",    16'h0006, 5'd4,  8'd0, -1, -1, 1'b0);
      play("div3",    16'h0006, 5'd4,  8'd3, -1, -1, 1'b0);
      play("len0",    16'hFFFF, 5'd0,  8'd0, -1, -1, 1'b0);
      play("len31",   16'hA5C3, 5'd31, 8'd0, -1, -1, 1'b1);
      play("restart", 16'h00B4, 5'd6,  8'd1, -1,  3, 1'b0);
      play("abort",   16'h005B, 5'd8,  8'd2,  1, -1, 1'b0);

      // Reset in the middle of SEND, after one counted hit.
      bus.pat   = 16'h00FF;
      bus.len   = 5'd8;
      bus.div   = 8'd3;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("pre_rst.busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      check("rst1.fsm_clr", 32'(bus.fsm_clr), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check_all_zero("mid_rst");

      play("post_rst", 16'h0006, 5'd4, 8'd0, -1, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
